regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write core register file.
- Provides NRD combinational read ports and two synchronous write ports:
  - port 1 carries ALU writeback.
  - port 2 carries load writeback, or base update on writeback addressing.
- The PC index is virtual: reads of it return the pc_val input, and writes to it are discarded.
- Adds a sequenced clear engine: the whole file is zeroed on request without asserting reset.
- Sits between decode (read addresses) and writeback (write ports) in the core datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register index width; NREG = 2**ADDR_W.
- NRD, 3, number of read ports (third port used for register-shifted-register operands).
- PC_IDX, 15, index mapped to pc_val; never stored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd  out  NRD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
- pc_val  in  DATA_W  value returned for reads of PC_IDX.
- we1  in  1  write enable, port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- we2  in  1  write enable, port 2.
- wa2  in  ADDR_W  write address, port 2.
- wd2  in  DATA_W  write data, port 2.
- clr_req  in  1  start clear sweep; sampled in IDLE only.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- wr_conflict  out  1  registered; high for one cycle after a same-address dual write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREG-1 stored registers go to 0.
  - FSM goes to IDLE.
  - clr_busy=0, clr_done=0, wr_conflict=0.
  - Release is sampled on the next rising clk.
- Reads (combinational, zero latency):
  - Address == PC_IDX: rd_k = pc_val.
  - Otherwise: rd_k = stored value.
  - Storage holds only the NREG-1 non-PC entries.
- Writes (on rising clk):
  - Port p writes when we_p=1, wa_p != PC_IDX and FSM is IDLE.
  - Write data is visible on rd from the following cycle (see optional feature for same-cycle visibility).
  - Writes with address PC_IDX are dropped silently.
- Dual-write conflict:
  - Condition: we1 and we2 both high and wa1 == wa2 != PC_IDX.
  - Port 2 data wins.
  - wr_conflict=1 in the next cycle only.
  - A conflict on PC_IDX does not raise wr_conflict.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 moves to SWEEP with idx=0.
  - SWEEP:
    - Each cycle, writes 0 to entry idx (skipped when idx == PC_IDX, but the cycle is still spent) and increments idx.
    - When idx == NREG-1, moves to DONE after that cycle.
    - clr_busy=1 for exactly NREG cycles.
  - DONE: clr_done=1 for one cycle, then returns to IDLE. clr_busy=0.
- During SWEEP and DONE:
  - Both write ports are ignored; no conflict flag is raised.
  - Reads of non-PC indices return 0.
  - Reads of PC_IDX still return pc_val.
- clr_req while not IDLE is ignored; it is not queued.
- clr_req held high continuously restarts a new sweep on the cycle after DONE.
- Reset asserted mid-sweep aborts it: all entries read 0 and the FSM is IDLE; clr_done does not pulse.
- idx counter width is ADDR_W. Wrap never occurs, because the FSM exits at NREG-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an active, accepted write (IDLE, we_p=1, wa_p != PC_IDX) returns that write data in the same cycle.
  - If both ports match, wd2 is returned.
  - This removes the writeback-to-decode hazard stall.
- Undefined: reads return the pre-write stored value, and the new value appears the next cycle.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then read all indices → 0 except index 15 = pc_val (pc_val = 0x0000_0108).
- we1=1, wa1=3, wd1=0xDEADBEEF; read ra0=3 in the same cycle and in the next cycle → same cycle: 0 (no bypass) or 0xDEADBEEF (bypass); next cycle: 0xDEADBEEF.
- Same cycle: we1 with wa1=5, wd1=0x11; we2 with wa2=5, wd2=0x22 → R5 = 0x22; wr_conflict=1 for exactly one cycle.
- we2=1, wa2=15, wd2=0xFFFF_FFFF → index 15 still reads pc_val; no other register changes; wr_conflict stays 0.
- Load R0..R14 with distinct values, pulse clr_req, and attempt we1 to R2 during the sweep →
  - clr_busy high for 16 cycles.
  - clr_done pulses on cycle 17.
  - All registers read 0 afterwards.
  - The R2 write is dropped.
- Start a sweep, assert rst_n low at sweep cycle 6, then release → IDLE; clr_busy=0; clr_done never pulses; all registers read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port core register file, NRD combinational reads and two
// synchronous write ports, a virtual PC index and a sequenced clear engine.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ra / rd             NRD packed read addresses / read data (port k at slice k)
//   pc_val              value returned for reads of PC_IDX
//   we1/wa1/wd1         write port 1 (ALU writeback)
//   we2/wa2/wd2         write port 2 (load / base writeback); wins on conflict
//   clr_req             start a clear sweep (sampled in IDLE only)
//   clr_busy, clr_done  sweep in progress / one-cycle completion pulse
//   wr_conflict         registered same-address dual-write flag
//
// Build option: define REGFILE_BYPASS_EN to forward an accepted write to
// same-cycle reads of the same index (port 2 data has priority).

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3,
    parameter int PC_IDX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD*ADDR_W-1:0]  ra,
    output logic [NRD*DATA_W-1:0]  rd,
    input  logic [DATA_W-1:0]      pc_val,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      wa1,
    input  logic [DATA_W-1:0]      wd1,
    input  logic                   we2,
    input  logic [ADDR_W-1:0]      wa2,
    input  logic [DATA_W-1:0]      wd2,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   wr_conflict
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                conflict_q, conflict_d;

    logic                idle;
    logic                wr1_ok, wr2_ok;
    logic [DATA_W-1:0]   ent [NREG];
    logic [ADDR_W-1:0]   rd_a;

    // Writes are only accepted while the clear engine is idle
    assign idle   = (state_q == S_IDLE);
    assign wr1_ok = idle && we1 && (wa1 != PC_A);
    assign wr2_ok = idle && we2 && (wa2 != PC_A);

    //------------------------------------------------------------------
    // Clear engine
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                // Hold idx on the last entry so the counter never wraps
                if (idx_q == LAST_A) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_busy = (state_q == S_SWEEP);
    assign clr_done = (state_q == S_DONE);

    //------------------------------------------------------------------
    // Conflict flag
    //------------------------------------------------------------------
    assign conflict_d = wr1_ok && wr2_ok && (wa1 == wa2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    //------------------------------------------------------------------
    // Storage: one register per non-PC index; the PC slot is a constant
    //------------------------------------------------------------------
    for (genvar g = 0; g < NREG; g++) begin : g_ent
        if (g == PC_IDX) begin : g_pc
            assign ent[g] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] val_q;
            logic              hit1, hit2, sweep_hit;

            assign hit1      = wr1_ok && (wa1 == ADDR_W'(g));
            assign hit2      = wr2_ok && (wa2 == ADDR_W'(g));
            assign sweep_hit = (state_q == S_SWEEP)
                            && (idx_q == ADDR_W'(g));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_q <= '0;
                end else if (sweep_hit) begin
                    val_q <= '0;
                end else if (hit2) begin
                    val_q <= wd2;
                end else if (hit1) begin
                    val_q <= wd1;
                end
            end

            assign ent[g] = val_q;
        end
    end

    //------------------------------------------------------------------
    // Read ports
    //------------------------------------------------------------------
    always_comb begin
        rd   = '0;
        rd_a = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_a = ra[k*ADDR_W +: ADDR_W];
            if (rd_a == PC_A) begin
                rd[k*DATA_W +: DATA_W] = pc_val;
            end else if (!idle) begin
                // Entries not yet swept still hold data; mask them
                rd[k*DATA_W +: DATA_W] = '0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (wr2_ok && (wa2 == rd_a)) begin
                    rd[k*DATA_W +: DATA_W] = wd2;
                end else if (wr1_ok && (wa1 == rd_a)) begin
                    rd[k*DATA_W +: DATA_W] = wd1;
                end else begin
                    rd[k*DATA_W +: DATA_W] = ent[rd_a];
                end
`else
                rd[k*DATA_W +: DATA_W] = ent[rd_a];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// Expected values are queued when stimulus is driven and popped on compare.

module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NRD  = 3;
    localparam int NREG = 16;
    localparam int PC   = 15;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*DW-1:0]   rd;
    logic [DW-1:0]       pc_val;
    logic                we1, we2;
    logic [AW-1:0]       wa1, wa2;
    logic [DW-1:0]       wd1, wd2;
    logic                clr_req;
    logic                clr_busy, clr_done, wr_conflict;

    int                  n_cmp = 0;
    int                  n_err = 0;
    logic [DW-1:0]       exp_q [$];
    logic [DW-1:0]       model [NREG];
    logic [DW-1:0]       got, exp_v;

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NRD),
        .PC_IDX (PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra          (ra),
        .rd          (rd),
        .pc_val      (pc_val),
        .we1         (we1),
        .wa1         (wa1),
        .wd1         (wd1),
        .we2         (we2),
        .wa2         (wa2),
        .wd2         (wd2),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int k, input int a);
        ra[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] rdp(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic no_writes();
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        we2 = 1'b0; wa2 = '0; wd2 = '0;
    endtask

    function automatic logic [DW-1:0] expect_reg(input int i);
        return (i == PC) ? pc_val : model[i];
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        clr_req = 1'b0;
        pc_val  = 32'h0000_0108;
        ra      = '0;
        no_writes();
        for (int i = 0; i < NREG; i++) model[i] = '0;
        tick();
        tick();
        exp_q.push_back(32'd0);
        @(negedge clk);
        got = {29'd0, clr_busy, clr_done, wr_conflict};
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL reset_flags got=%h exp=%h", got, exp_v);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int i = 0; i < NREG; i++) exp_q.push_back(expect_reg(i));
        for (int i = 0; i < NREG; i++) begin
            set_ra(i % NRD, i);
            #1;
            got = rdp(i % NRD);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL reset_read[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'hDEAD_BEEF;
        set_ra(0, 3);
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hDEAD_BEEF);
`else
        exp_q.push_back(32'd0);
`endif
        #2;
        got = rdp(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL wr_same_cycle got=%h exp=%h", got, exp_v);
        end
        model[3] = 32'hDEAD_BEEF;
        tick();
        no_writes();
        exp_q.push_back(model[3]);
        #1;
        got = rdp(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL wr_next_cycle got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_conflict();
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h11;
        we2 = 1'b1; wa2 = 4'd5; wd2 = 32'h22;
        model[5] = 32'h22;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = {31'd0, wr_conflict};
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL conflict_flag[%0d] got=%h exp=%h", c, got, exp_v);
            end
            tick();
            no_writes();
        end
        set_ra(1, 5);
        exp_q.push_back(model[5]);
        #1;
        got = rdp(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL conflict_data got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_pc_write();
        we2 = 1'b1; wa2 = 4'd15; wd2 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h1234_5678;
        tick();
        no_writes();
        exp_q.push_back(32'd0);
        @(negedge clk);
        got = {31'd0, wr_conflict};
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL pc_conflict got=%h exp=%h", got, exp_v);
        end
        for (int i = 0; i < NREG; i++) exp_q.push_back(expect_reg(i));
        for (int i = 0; i < NREG; i++) begin
            set_ra(2, i);
            #1;
            got = rdp(2);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL pc_write_read[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_clear();
        tick();
        for (int i = 0; i < PC; i += 2) begin
            we1 = 1'b1; wa1 = AW'(i); wd1 = $urandom();
            model[i] = wd1;
            if (i + 1 < PC) begin
                we2 = 1'b1; wa2 = AW'(i + 1); wd2 = $urandom();
                model[i+1] = wd2;
            end else begin
                we2 = 1'b0;
            end
            tick();
        end
        no_writes();
        for (int i = 0; i < NREG; i++) exp_q.push_back(expect_reg(i));
        for (int i = 0; i < NREG; i++) begin
            set_ra(i % NRD, i);
            #1;
            got = rdp(i % NRD);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL load_read[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        set_ra(0, 2);
        set_ra(1, 15);
        set_ra(2, 7);
        for (int i = 0; i < NREG; i++) model[i] = '0;
        // per cycle: {busy,done,conflict}, rd0, rd1, rd2
        for (int c = 1; c <= 20; c++) begin
            exp_q.push_back({29'd0, (c <= 16), (c == 17), 1'b0});
            exp_q.push_back(32'd0);
            exp_q.push_back(pc_val);
            exp_q.push_back(32'd0);
        end
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) begin
                we1 = 1'b1; wa1 = 4'd2; wd1 = 32'hAAAA_5555;
                we2 = 1'b1; wa2 = 4'd2; wd2 = 32'h5555_AAAA;
            end else begin
                no_writes();
            end
            @(negedge clk);
            got = {29'd0, clr_busy, clr_done, wr_conflict};
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL sweep_flags[%0d] got=%h exp=%h", c, got, exp_v);
            end
            for (int k = 0; k < NRD; k++) begin
                got = rdp(k);
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (got !== exp_v) begin
                    n_err++;
                    $display("FAIL sweep_rd%0d[%0d] got=%h exp=%h", k, c, got, exp_v);
                end
            end
            tick();
        end
        no_writes();
        for (int i = 0; i < NREG; i++) exp_q.push_back(expect_reg(i));
        for (int i = 0; i < NREG; i++) begin
            set_ra(i % NRD, i);
            #1;
            got = rdp(i % NRD);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL clear_read[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        we1 = 1'b1; wa1 = 4'd9;  wd1 = 32'h0000_0099;
        we2 = 1'b1; wa2 = 4'd14; wd2 = 32'h0000_00EE;
        tick();
        no_writes();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        exp_q.push_back(32'd0);
        #1;
        got = {30'd0, clr_busy, clr_done};
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL abort_flags got=%h exp=%h", got, exp_v);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) exp_q.push_back(32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got = {30'd0, clr_busy, clr_done};
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL abort_idle[%0d] got=%h exp=%h", c, got, exp_v);
            end
            tick();
        end
        for (int i = 0; i < NREG; i++) exp_q.push_back(expect_reg(i));
        for (int i = 0; i < NREG; i++) begin
            set_ra(i % NRD, i);
            #1;
            got = rdp(i % NRD);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL abort_read[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_pc_write();
        test_clear();
        test_reset_mid_sweep();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
